// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: constants and helpers shared by stream_mux and its sub-module.
//   MODE_SEL : channel chosen by the external sel input.
//   MODE_RR  : channel chosen by a rotating round-robin search.
//   wrap_inc : idx+1, wrapping to 0 after n-1 (round-robin pointer update).
package stream_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_pick.sv
// rr_pick: rotating first-valid search.
// Finds the first asserted req bit, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
// Ports:
//   req   [N-1:0]    in  : request vector (one bit per channel)
//   ptr   [SELW-1:0] in  : channel where the scan starts (always < N)
//   found            out : some request bit is set
//   idx   [SELW-1:0] out : index of the first request found (0 when none)
module rr_pick #(
  parameter int N = 16,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      int c;
      // ptr < N, so one subtraction is enough to wrap the scan position.
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = SELW'(c);
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// stream_mux: N-to-1 stream multiplexer with a single registered output stage.
// Channel choice is either the external sel input (MODE_SEL) or a round-robin
// search starting at an internal pointer (MODE_RR).
//
// Handshake: a beat moves across an interface on a rising edge where valid and
// ready are both 1. A source holding valid keeps it and its data until ready;
// ready may rise and fall freely. Here in_ready is granted to at most one channel
// and only when the output register can load (empty, or emptying this cycle).
//
// Ports:
//   clk                     in  : sole clock, rising edge
//   reset                   in  : synchronous active-high reset
//   in_data   [N*W-1:0]     in  : flattened payloads, channel i at [i*W +: W]
//   in_valid  [N-1:0]       in  : per-channel valid
//   in_ready  [N-1:0]       out : per-channel ready (one-hot or zero)
//   sel       [SELW-1:0]    in  : channel select (MODE_SEL only)
//   out_data  [W-1:0]       out : registered payload
//   out_valid               out : out_data holds a beat
//   out_ready               in  : downstream accepts
//   out_chan  [SELW-1:0]    out : source channel of the held beat
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int W    = 8,
  parameter int N    = 16,
  parameter int MODE = MODE_SEL,
  localparam int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic [SELW-1:0]   sel,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SELW-1:0]   out_chan
);

  logic            load;
  logic            sel_ok;
  logic            rr_found;
  logic [SELW-1:0] rr_idx;
  logic            grant_found;
  logic [SELW-1:0] grant_idx;
  logic            xfer;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] ptr_next;

  // Output register may take a new beat when empty or being drained this cycle.
  assign load = !out_valid || out_ready;

  // When N is not a power of two, sel can name a channel that does not exist.
  assign sel_ok = (int'(sel) < N);

  generate
    if (MODE == MODE_RR) begin : g_rr
      rr_pick #(.N(N)) u_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .found (rr_found),
        .idx   (rr_idx)
      );
    end else begin : g_sel
      assign rr_found = 1'b0;
      assign rr_idx   = '0;
    end
  endgenerate

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    if (MODE == MODE_RR) begin
      grant_found = rr_found;
      grant_idx   = rr_idx;
    end else begin
      grant_found = sel_ok;
      grant_idx   = sel;
    end
  end

  // Ready never looks at in_data; reset blocks every grant.
  always_comb begin
    in_ready = '0;
    if (!reset && load && grant_found) in_ready[grant_idx] = 1'b1;
  end

  assign xfer = |(in_valid & in_ready);

  // Pointer moves just past the channel that was served; it stays put otherwise.
  always_comb begin
    ptr_next = ptr;
    if (xfer) ptr_next = SELW'(wrap_inc(int'(grant_idx), N));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[grant_idx*W +: W];
        out_chan  <= grant_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      ptr <= ptr_next;
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
module tb_stream_mux;

  localparam int W    = 8;
  localparam int N    = 16;
  localparam int SELW = $clog2(N);

  // ---------------- clock / reset / shared stimulus ----------------
  logic            clk = 1'b0;
  logic            reset;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [SELW-1:0] sel;
  logic            out_ready;

  // index 0: MODE_SEL instance, index 1: MODE_RR instance
  logic [N-1:0]    rdy     [2];
  logic [W-1:0]    o_data  [2];
  logic            o_valid [2];
  logic [SELW-1:0] o_chan  [2];

  always #5 clk = ~clk;

  stream_mux #(.W(W), .N(N), .MODE(0)) dut_sel (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (rdy[0]),
    .sel       (sel),
    .out_data  (o_data[0]),
    .out_valid (o_valid[0]),
    .out_ready (out_ready),
    .out_chan  (o_chan[0])
  );

  stream_mux #(.W(W), .N(N), .MODE(1)) dut_rr (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (rdy[1]),
    .sel       (sel),
    .out_data  (o_data[1]),
    .out_valid (o_valid[1]),
    .out_ready (out_ready),
    .out_chan  (o_chan[1])
  );

  // ---------------- counters / compare ----------------
  int n_cmp;
  int n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Output register contents per instance, round-robin pointer, and the
  // expected queues of beats ({chan, data}) accepted but not yet delivered.
  logic            m_valid [2];
  logic [W-1:0]    m_data  [2];
  logic [SELW-1:0] m_chan  [2];
  int              m_ptr;
  logic [SELW+W-1:0] exp_q0[$];
  logic [SELW+W-1:0] exp_q1[$];

  // Granted channel for instance m under the current inputs, -1 if none.
  function automatic int grant_of(input int m);
    if (m == 0) return (int'(sel) < N) ? int'(sel) : -1;
    for (int k = 0; k < N; k++)
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] ready_of(input int m);
    logic [N-1:0] r;
    int g;
    r = '0;
    g = grant_of(m);
    if (!reset && (!m_valid[m] || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic check_now();
    logic [SELW+W-1:0] beat;
    int sz;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("m%0d_out_valid", m), 32'(o_valid[m]), 32'(m_valid[m]));
      if (m_valid[m]) begin
        check($sformatf("m%0d_out_data", m), 32'(o_data[m]), 32'(m_data[m]));
        check($sformatf("m%0d_out_chan", m), 32'(o_chan[m]), 32'(m_chan[m]));
      end
      check($sformatf("m%0d_in_ready", m), 32'(rdy[m]), 32'(ready_of(m)));
      if (o_valid[m] === 1'b1 && out_ready) begin
        sz = (m == 0) ? exp_q0.size() : exp_q1.size();
        if (sz == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL m%0d_sb: delivered chan %0d data 0x%0h, none expected", m, o_chan[m], o_data[m]);
        end else begin
          if (m == 0) beat = exp_q0.pop_front();
          else        beat = exp_q1.pop_front();
          check($sformatf("m%0d_sb", m), 32'({o_chan[m], o_data[m]}), 32'(beat));
        end
      end
    end
  endtask

  task automatic update_model();
    int g;
    logic [N-1:0] r;
    for (int m = 0; m < 2; m++) begin
      g = grant_of(m);
      r = ready_of(m);
      if (reset) begin
        m_valid[m] = 1'b0;
        m_data[m]  = '0;
        m_chan[m]  = '0;
        if (m == 1) m_ptr = 0;
        if (m == 0) exp_q0.delete();
        else        exp_q1.delete();
      end else if (g >= 0 && r[g] && in_valid[g]) begin
        m_valid[m] = 1'b1;
        m_data[m]  = in_data[g*W +: W];
        m_chan[m]  = SELW'(g);
        if (m == 0) exp_q0.push_back({SELW'(g), in_data[g*W +: W]});
        else        exp_q1.push_back({SELW'(g), in_data[g*W +: W]});
        if (m == 1) m_ptr = (g + 1) % N;
      end else if (out_ready) begin
        m_valid[m] = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are set at posedge+1; outputs are checked at the negedge.
  task automatic tick();
    @(negedge clk);
    check_now();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
  endtask

  // ---------------- MODE_SEL vector table ----------------
  typedef struct {
    logic [SELW-1:0] sel;
    logic [N-1:0]    valid;
    logic [W-1:0]    data;
    logic [N-1:0]    exp_ready;
    logic            exp_ov;
  } vec_t;

  vec_t tbl[6];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 1'b0;
      m_data[m]  = '0;
      m_chan[m]  = '0;
    end
    m_ptr = 0;

    tbl[0] = '{sel: 4'd5,  valid: 16'h0020, data: 8'hA5, exp_ready: 16'h0020, exp_ov: 1'b1};
    tbl[1] = '{sel: 4'd5,  valid: 16'h0000, data: 8'h00, exp_ready: 16'h0020, exp_ov: 1'b0};
    tbl[2] = '{sel: 4'd0,  valid: 16'hFFFF, data: 8'h3C, exp_ready: 16'h0001, exp_ov: 1'b1};
    tbl[3] = '{sel: 4'd15, valid: 16'h8000, data: 8'hC3, exp_ready: 16'h8000, exp_ov: 1'b1};
    tbl[4] = '{sel: 4'd3,  valid: 16'hFFF7, data: 8'h77, exp_ready: 16'h0008, exp_ov: 1'b0};
    tbl[5] = '{sel: 4'd9,  valid: 16'h0200, data: 8'h5A, exp_ready: 16'h0200, exp_ov: 1'b1};

    // ---- reset with every channel valid ----
    reset     = 1'b1;
    in_valid  = '1;
    out_ready = 1'b1;
    sel       = 4'd5;
    rand_data();
    tick();
    tick();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("rst_m%0d_valid", m), 32'(o_valid[m]), 32'd0);
      check($sformatf("rst_m%0d_data", m),  32'(o_data[m]),  32'd0);
      check($sformatf("rst_m%0d_chan", m),  32'(o_chan[m]),  32'd0);
      check($sformatf("rst_m%0d_ready", m), 32'(rdy[m]),     32'd0);
    end
    reset = 1'b0;

    // ---- MODE_SEL table ----
    for (int i = 0; i < 6; i++) begin
      sel      = tbl[i].sel;
      in_valid = tbl[i].valid;
      rand_data();
      in_data[int'(tbl[i].sel)*W +: W] = tbl[i].data;
      #1;
      check($sformatf("tbl%0d_ready", i), 32'(rdy[0]), 32'(tbl[i].exp_ready));
      tick();
      check($sformatf("tbl%0d_valid", i), 32'(o_valid[0]), 32'(tbl[i].exp_ov));
      if (tbl[i].exp_ov) begin
        check($sformatf("tbl%0d_data", i), 32'(o_data[0]), 32'(tbl[i].data));
        check($sformatf("tbl%0d_chan", i), 32'(o_chan[0]), 32'(tbl[i].sel));
      end
    end

    // ---- stall: held beat survives sel/data changes ----
    sel      = 4'd2;
    in_valid = '1;
    rand_data();
    in_data[2*W +: W] = 8'h11;
    tick();
    check("stall_load_data", 32'(o_data[0]), 32'h11);
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = SELW'(7 + 2 * s);
      rand_data();
      #1;
      check("stall_ready", 32'(rdy[0]), 32'd0);
      tick();
      check("stall_data", 32'(o_data[0]), 32'h11);
      check("stall_chan", 32'(o_chan[0]), 32'd2);
      check("stall_valid", 32'(o_valid[0]), 32'd1);
    end
    out_ready = 1'b1;
    sel = 4'd12;
    rand_data();
    in_data[12*W +: W] = 8'h22;
    tick();
    check("resume_data", 32'(o_data[0]), 32'h22);
    check("resume_chan", 32'(o_chan[0]), 32'd12);
    in_valid = '0;
    tick();
    check("resume_drain", 32'(o_valid[0]), 32'd0);

    // ---- round-robin over all channels, one beat per cycle ----
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = '1;
    for (int k = 0; k <= N; k++) begin
      rand_data();
      tick();
      check($sformatf("rr_seq%0d_chan", k), 32'(o_chan[1]), 32'(k % N));
      check($sformatf("rr_seq%0d_valid", k), 32'(o_valid[1]), 32'd1);
    end

    // ---- wrap-around from ptr=14 ----
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 16'h2000;
    tick();
    check("wrap_setup_chan", 32'(o_chan[1]), 32'd13);
    in_valid = 16'h8008;
    tick();
    check("wrap_first_chan", 32'(o_chan[1]), 32'd15);
    tick();
    check("wrap_second_chan", 32'(o_chan[1]), 32'd3);
    in_valid = 16'h0018;
    #1;
    check("wrap_ptr4_ready", 32'(rdy[1]), 32'h0010);
    tick();
    check("wrap_ptr4_chan", 32'(o_chan[1]), 32'd4);

    // ---- reset mid-stream after channel 7 ----
    in_valid = 16'h0080;
    tick();
    check("midrst_chan7", 32'(o_chan[1]), 32'd7);
    out_ready = 1'b0;
    reset     = 1'b1;
    in_valid  = '0;
    tick();
    check("midrst_dropped", 32'(o_valid[1]), 32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 16'h1204;
    #1;
    check("midrst_ready", 32'(rdy[1]), 32'h0004);
    tick();
    check("midrst_chan", 32'(o_chan[1]), 32'd2);

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sel       = SELW'($urandom);
      in_valid  = N'($urandom);
      if ($urandom_range(0, 1) == 1) in_valid = in_valid & N'($urandom) & N'($urandom);
      rand_data();
      tick();
    end

    // ---- drain and confirm nothing was lost ----
    reset     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("drain_q0_empty", 32'(exp_q0.size()), 32'd0);
    check("drain_q1_empty", 32'(exp_q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 SHALL have parameter W, default 8: payload width per channel in bits.
REQ-002 SHALL have parameter N, default 16: channel count, N >= 2.
REQ-003 SHALL have parameter MODE, default 0: 0 = externally selected channel, 1 = round-robin arbitration.
REQ-004 SHALL derive local constant SELW = $clog2(N), not overridable.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-008 SHALL have port in_data, input, N*W: flattened payloads, channel i at bits [i*W +: W].
REQ-009 SHALL have port in_valid, input, N: per-channel valid.
REQ-010 SHALL have port in_ready, output, N: per-channel ready.
REQ-011 SHALL have port sel, input, SELW: channel select, used only when MODE=0.
REQ-012 SHALL have port out_data, output, W: registered selected payload.
REQ-013 SHALL have port out_valid, output, 1: out_data holds a beat.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts.
REQ-015 SHALL have port out_chan, output, SELW: source channel of the held beat.

Function
REQ-016 SHALL define load = !out_valid || out_ready; the output register accepts a new beat only when load=1.
REQ-017 SHALL assert at most one in_ready bit per cycle, only for the granted channel and only when load=1.
REQ-018 SHALL transfer a beat from channel g when in_valid[g] && in_ready[g]; out_data <= in_data[g*W +: W], out_chan <= g, out_valid <= 1 on the next edge (latency 1 cycle).
REQ-019 SHALL clear out_valid on an edge where out_ready=1 and no transfer occurs.
REQ-020 SHALL hold out_data, out_chan and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL sustain one beat per cycle when out_ready is held at 1 and a granted input is valid.
REQ-022 MODE=0: SHALL grant channel sel; if sel >= N, no grant and all in_ready = 0.
REQ-023 MODE=0: a sel change while stalled SHALL not alter the held output.
REQ-024 MODE=1: SHALL keep a pointer ptr of width SELW; grant goes to the first channel with in_valid=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-025 MODE=1: after a transfer from g, ptr SHALL become g+1, or 0 if g = N-1; ptr SHALL be unchanged when no transfer occurs.
REQ-026 MODE=1: with no valid input, there is no grant and all in_ready = 0.
REQ-027 in_ready SHALL depend combinationally on in_valid (MODE=1), sel (MODE=0), out_valid and out_ready; it SHALL never depend on in_data.
REQ-028 SHALL have no combinational path from in_data to out_data.

Reset
REQ-029 While reset=1 at an edge: out_valid <= 0, out_data <= 0, out_chan <= 0, ptr <= 0.
REQ-030 Reset SHALL take priority over a simultaneous transfer; an in-flight beat is discarded.
REQ-031 in_ready SHALL be 0 in any cycle where reset=1.

Structure
REQ-032 Shared package stream_mux_pkg SHALL hold the constants MODE_SEL=0 and MODE_RR=1.
REQ-033 SHALL instantiate one sub-module, rr_pick (parameter N), for the rotating first-valid search; the sub-module is used only when MODE=1.
REQ-034 All state SHALL be in one always block on posedge clk; the grant logic SHALL be combinational.

Verification
REQ-035 Reset: assert reset with all in_valid=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=0 during reset.
REQ-036 MODE=0, W=8, N=16, sel=5, in_valid[5]=1, channel 5 data=8'hA5, out_ready=1 -> in_ready=16'h0020; next cycle out_data=8'hA5, out_chan=5.
REQ-037 Stall: out_valid=1, out_ready=0 for 3 cycles, with sel changing and new data -> out_data and out_chan unchanged, in_ready=0; on out_ready=1, transfers resume with no beat lost or duplicated.
REQ-038 MODE=1, all 16 valid, out_ready=1 continuously -> out_chan sequence 0,1,...,15,0 with one beat per cycle.
REQ-039 MODE=1, ptr=14, only channels 3 and 15 valid -> 15 is granted first, then 3 (wrap-around), then ptr=4.
REQ-040 Reset mid-stream in MODE=1 after channel 7 -> held beat dropped, ptr=0, and the next grant is the lowest valid channel.
